// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// Segment bit order on the abcdefgh bus: bit7 = a ... bit1 = g, bit0 = h (decimal point).
package seven_seg_pkg;

  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_H = 0;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Glyph for one hex nibble; the decimal point bit is always returned as 0.
  function automatic logic [7:0] hex_to_7seg(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = 8'hFC;
      4'h1:    seg = 8'h60;
      4'h2:    seg = 8'hDA;
      4'h3:    seg = 8'hF2;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'hB6;
      4'h6:    seg = 8'hBE;
      4'h7:    seg = 8'hE0;
      4'h8:    seg = 8'hFE;
      4'h9:    seg = 8'hF6;
      4'hA:    seg = 8'hEE;
      4'hB:    seg = 8'h3E;
      4'hC:    seg = 8'h9C;
      4'hD:    seg = 8'h7A;
      4'hE:    seg = 8'h9E;
      4'hF:    seg = 8'h8E;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// User-side load bus and board-side display pins of the scan driver.
// master = user logic / board model, slave = the driver itself.
interface seven_segment_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dots;
  logic [N_DIGITS-1:0]     digit_en;
  logic [7:0]              abcdefgh;
  logic [N_DIGITS-1:0]     digit;
  logic                    frame_done;

  modport master (
    output load, value, dots, digit_en,
    input  abcdefgh, digit, frame_done
  );

  modport slave (
    input  load, value, dots, digit_en,
    output abcdefgh, digit, frame_done
  );
endinterface

// File: rtl/seven_seg_leading_zero_mask.sv
// Leading-zero mask: keeps digit 0 and every digit at or below the top nonzero nibble.
// Present only when SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined.
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
module seven_seg_leading_zero_mask #(
  parameter int N_DIGITS = 8
) (
  input  logic [4*N_DIGITS-1:0] nibbles_s,
  output logic [N_DIGITS-1:0]   keep_s
);

  // Sweep from the most significant digit down, latching once a nonzero nibble is seen.
  always_comb begin
    logic seen_s;
    seen_s = 1'b0;
    keep_s = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      seen_s    = seen_s | (nibbles_s[4*i +: 4] != 4'h0);
      keep_s[i] = seen_s | (i == 0);
    end
  end

endmodule
`endif

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with load/frame-boundary double buffering.
// Optional leading-zero blanking under SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS         = 8,
  parameter int CYCLES_PER_DIGIT = 27000,
  parameter int BLANK_CYCLES     = 270
) (
  input  logic                        clock,
  input  logic                        reset,
  seven_segment_scan_driver_if.slave  bus
);

  localparam int MAX_DWELL = (CYCLES_PER_DIGIT > BLANK_CYCLES) ? CYCLES_PER_DIGIT : BLANK_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);
  localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CYCLES_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  scan_state_t             state_r, state_next_s;
  logic [CNT_W-1:0]        cnt_r, cnt_next_s;
  logic [IDX_W-1:0]        idx_r, idx_next_s;
  logic                    transfer_s;
  logic                    frame_done_r, frame_done_next_s;

  logic [4*N_DIGITS-1:0]   staging_value_r;
  logic [N_DIGITS-1:0]     staging_dots_r;
  logic [N_DIGITS-1:0]     staging_en_r;
  logic [N_DIGITS-1:0]     staging_keep_s;

  logic [4*N_DIGITS-1:0]   shadow_value_r, shadow_value_next_s;
  logic [N_DIGITS-1:0]     shadow_dots_r, shadow_dots_next_s;
  logic [N_DIGITS-1:0]     shadow_en_r, shadow_en_next_s;
  logic [N_DIGITS-1:0]     shadow_keep_r, shadow_keep_next_s;

  logic [7:0]              abcdefgh_r, abcdefgh_next_s;
  logic [N_DIGITS-1:0]     digit_r, digit_next_s;
  logic [N_DIGITS-1:0]     onehot_s;
  logic [3:0]              nibble_s;
  logic [7:0]              glyph_s;
  logic                    en_sel_s, keep_sel_s, dot_sel_s;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Suppression is evaluated on the value about to become the shadow copy.
  seven_seg_leading_zero_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_lz_mask (
    .nibbles_s (staging_value_r),
    .keep_s    (staging_keep_s)
  );
`else
  assign staging_keep_s = {N_DIGITS{1'b1}};
`endif

  // Scan sequencer: dwell counting, digit index advance and frame-boundary detection.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r + CNT_W'(1);
    idx_next_s        = idx_r;
    transfer_s        = 1'b0;
    frame_done_next_s = 1'b0;
    case (state_r)
      BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_next_s = SHOW;
          cnt_next_s   = {CNT_W{1'b0}};
          transfer_s   = (idx_r == {IDX_W{1'b0}});
        end else begin
          state_next_s = BLANK;
        end
      end
      SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_next_s      = BLANK;
          cnt_next_s        = {CNT_W{1'b0}};
          idx_next_s        = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
          frame_done_next_s = (idx_r == IDX_LAST);
        end else begin
          state_next_s = SHOW;
        end
      end
      default: begin
        state_next_s = BLANK;
        cnt_next_s   = {CNT_W{1'b0}};
        idx_next_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Shadow contents as they will be after this edge, so a new frame lights without a lag cycle.
  always_comb begin
    if (transfer_s) begin
      shadow_value_next_s = staging_value_r;
      shadow_dots_next_s  = staging_dots_r;
      shadow_en_next_s    = staging_en_r;
      shadow_keep_next_s  = staging_keep_s;
    end else begin
      shadow_value_next_s = shadow_value_r;
      shadow_dots_next_s  = shadow_dots_r;
      shadow_en_next_s    = shadow_en_r;
      shadow_keep_next_s  = shadow_keep_r;
    end
  end

  // Next pin values: a suppressed digit with its dot set keeps select high and lights only h.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      onehot_s[i] = (idx_next_s == IDX_W'(i));
    end
    nibble_s        = shadow_value_next_s[{idx_next_s, 2'b00} +: 4];
    glyph_s         = hex_to_7seg(nibble_s);
    en_sel_s        = shadow_en_next_s[idx_next_s];
    keep_sel_s      = shadow_keep_next_s[idx_next_s];
    dot_sel_s       = shadow_dots_next_s[idx_next_s];
    digit_next_s    = {N_DIGITS{1'b0}};
    abcdefgh_next_s = 8'h00;
    if (state_next_s == SHOW) begin
      if (en_sel_s && keep_sel_s) begin
        digit_next_s                  = onehot_s;
        abcdefgh_next_s[SEG_A:SEG_G]  = glyph_s[SEG_A:SEG_G];
        abcdefgh_next_s[SEG_H]        = dot_sel_s;
      end else if (en_sel_s && dot_sel_s) begin
        digit_next_s           = onehot_s;
        abcdefgh_next_s[SEG_H] = 1'b1;
      end else begin
        digit_next_s    = {N_DIGITS{1'b0}};
        abcdefgh_next_s = 8'h00;
      end
    end else begin
      digit_next_s    = {N_DIGITS{1'b0}};
      abcdefgh_next_s = 8'h00;
    end
  end

  // State, buffers and registered pins; reset also discards any pending staged load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= BLANK;
      cnt_r           <= {CNT_W{1'b0}};
      idx_r           <= {IDX_W{1'b0}};
      frame_done_r    <= 1'b0;
      staging_value_r <= {(4*N_DIGITS){1'b0}};
      staging_dots_r  <= {N_DIGITS{1'b0}};
      staging_en_r    <= {N_DIGITS{1'b0}};
      shadow_value_r  <= {(4*N_DIGITS){1'b0}};
      shadow_dots_r   <= {N_DIGITS{1'b0}};
      shadow_en_r     <= {N_DIGITS{1'b0}};
      shadow_keep_r   <= {N_DIGITS{1'b0}};
      abcdefgh_r      <= 8'h00;
      digit_r         <= {N_DIGITS{1'b0}};
    end else begin
      state_r         <= state_next_s;
      cnt_r           <= cnt_next_s;
      idx_r           <= idx_next_s;
      frame_done_r    <= frame_done_next_s;
      shadow_value_r  <= shadow_value_next_s;
      shadow_dots_r   <= shadow_dots_next_s;
      shadow_en_r     <= shadow_en_next_s;
      shadow_keep_r   <= shadow_keep_next_s;
      abcdefgh_r      <= abcdefgh_next_s;
      digit_r         <= digit_next_s;
      if (bus.load) begin
        staging_value_r <= bus.value;
        staging_dots_r  <= bus.dots;
        staging_en_r    <= bus.digit_en;
      end
    end
  end

  assign bus.abcdefgh   = abcdefgh_r;
  assign bus.digit      = digit_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver (N_DIGITS=4, CYCLES_PER_DIGIT=4, BLANK_CYCLES=1).
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN for both RTL and bench to cover the suppression variant.
module tb_seven_segment_scan_driver;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  seven_segment_scan_driver_if #(.N_DIGITS(4)) bus ();

  seven_segment_scan_driver #(
    .N_DIGITS         (4),
    .CYCLES_PER_DIGIT (4),
    .BLANK_CYCLES     (1)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] obs_s;
  assign obs_s = {bus.frame_done, bus.digit, bus.abcdefgh};

  // Expected {frame_done, digit, abcdefgh} at frame position p (0 = first lit cycle of digit 0).
  function automatic logic [12:0] exp_at(input int p, input logic [15:0] dig_pk, input logic [31:0] seg_pk);
    int slot;
    int off;
    slot = p / 5;
    off  = p % 5;
    if (off < 4) return {1'b0, dig_pk[slot*4 +: 4], seg_pk[slot*8 +: 8]};
    else         return {(slot == 3), 12'h000};
  endfunction

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    @(negedge clk);
    bus.load = 1'b1; bus.value = v; bus.dots = d; bus.digit_en = en;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Advance to the negedge sampling the frame_done cycle (the blank slot before digit 0).
  task automatic sync_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      $display("FAIL sync_frame: frame_done not seen in 40 cycles, got %b want 1", bus.frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load = 1'b0; bus.value = 16'h0000; bus.dots = 4'h0; bus.digit_en = 4'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_s !== 13'h0000) $display("FAIL reset i=%0d got %h want %h", i, obs_s, 13'h0000);
      else passes++;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_no_load();
    logic [12:0] e;
    sync_frame();
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h0000, 32'h0000_0000);
      checks++;
      if (obs_s !== e) $display("FAIL no_load p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  task automatic test_basic_display();
    logic [12:0] e;
    drive_load(16'h1A2F, 4'b0100, 4'hF);
    sync_frame();
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8421, 32'h60EF_DA8E);
      checks++;
      if (obs_s !== e) $display("FAIL basic p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  task automatic test_mid_frame_load();
    logic [12:0] e;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8421, 32'h60EF_DA8E);
      checks++;
      if (obs_s !== e) $display("FAIL mid_old p=%0d got %h want %h", p, obs_s, e);
      else passes++;
      if (p == 10) begin
        bus.load = 1'b1; bus.value = 16'h0000; bus.dots = 4'h0; bus.digit_en = 4'hF;
      end
      if (p == 11) bus.load = 1'b0;
    end
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8421, 32'hFCFC_FCFC);
      checks++;
      if (obs_s !== e) $display("FAIL mid_new p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  task automatic test_boundary_load();
    logic [12:0] e;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8421, 32'hFCFC_FCFC);
      checks++;
      if (obs_s !== e) $display("FAIL bnd_cur p=%0d got %h want %h", p, obs_s, e);
      else passes++;
      if (p == 5) begin
        bus.load = 1'b1; bus.value = 16'h4567; bus.dots = 4'h0; bus.digit_en = 4'hF;
      end
      if (p == 6) bus.load = 1'b0;
      if (p == 19) begin
        bus.load = 1'b1; bus.value = 16'hBCDE; bus.dots = 4'b1001; bus.digit_en = 4'hF;
      end
    end
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      if (p == 0) bus.load = 1'b0;
      e = exp_at(p, 16'h8421, 32'h66B6_BEE0);
      checks++;
      if (obs_s !== e) $display("FAIL bnd_old p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8421, 32'h3F9C_7A9F);
      checks++;
      if (obs_s !== e) $display("FAIL bnd_new p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_show();
    logic [12:0] e;
    for (int p = 0; p < 12; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8421, 32'h3F9C_7A9F);
      checks++;
      if (obs_s !== e) $display("FAIL rst_pre p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_s !== 13'h0000) $display("FAIL rst_mid got %h want %h", obs_s, 13'h0000);
    else passes++;
    rst = 1'b0;
    for (int p = 0; p < 40; p++) begin
      @(negedge clk);
      e = exp_at(p % 20, 16'h0000, 32'h0000_0000);
      checks++;
      if (obs_s !== e) $display("FAIL rst_post p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  task automatic test_digit_en();
    logic [12:0] e;
    drive_load(16'h8888, 4'h0, 4'b1010);
    sync_frame();
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, 16'h8020, 32'hFE00_FE00);
      checks++;
      if (obs_s !== e) $display("FAIL digit_en p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  task automatic test_leading_zero();
    logic [12:0] e;
    logic [15:0] dig0, dig1;
    logic [31:0] seg0, seg1;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    dig0 = 16'h0021; seg0 = 32'h0000_F2FC;
    dig1 = 16'h0421; seg1 = 32'h0001_F2FC;
`else
    dig0 = 16'h8421; seg0 = 32'hFCFC_F2FC;
    dig1 = 16'h8421; seg1 = 32'hFCFD_F2FC;
`endif
    drive_load(16'h0030, 4'h0, 4'hF);
    sync_frame();
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, dig0, seg0);
      checks++;
      if (obs_s !== e) $display("FAIL lzb p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
    drive_load(16'h0030, 4'b0100, 4'hF);
    sync_frame();
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      e = exp_at(p, dig1, seg1);
      checks++;
      if (obs_s !== e) $display("FAIL lzb_dot p=%0d got %h want %h", p, obs_s, e);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_no_load();
    test_basic_display();
    test_mid_frame_load();
    test_boundary_load();
    test_reset_mid_show();
    test_digit_en();
    test_leading_zero();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passes);
    $fatal(1, "watchdog");
  end

endmodule
